// File: rtl/ifu_pkg.sv
// Shared types and default widths for the instruction-fetch line fetcher.
package ifu_pkg;

  localparam int IDX_W  = 19;
  localparam int LINE_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/ifu_line_buf.sv
// One-entry line buffer: holds the last fetched line, answers hit lookups,
// and suppresses keeping a line whose fill raced with an invalidate.
module ifu_line_buf #(
  parameter int IDX_W  = ifu_pkg::IDX_W,
  parameter int LINE_W = ifu_pkg::LINE_W,
  parameter bit LB_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  lookup_index,
  input  logic              inv,
  input  logic              in_idle,
  input  logic              in_flight,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [LINE_W-1:0] fill_data,
  output logic              hit,
  output logic [LINE_W-1:0] lb_data
);
  import ifu_pkg::*;

  logic              lb_valid_reg, lb_valid_next;
  logic [IDX_W-1:0]  lb_index_reg, lb_index_next;
  logic [LINE_W-1:0] lb_data_reg, lb_data_next;
  logic              no_fill_reg, no_fill_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lb_valid_reg <= 1'b0;
      lb_index_reg <= '0;
      lb_data_reg  <= '0;
      no_fill_reg  <= 1'b0;
    end else begin
      lb_valid_reg <= lb_valid_next;
      lb_index_reg <= lb_index_next;
      lb_data_reg  <= lb_data_next;
      no_fill_reg  <= no_fill_next;
    end
  end

  always_comb begin
    lb_valid_next = lb_valid_reg & ~inv;
    lb_index_next = lb_index_reg;
    lb_data_next  = lb_data_reg;
    no_fill_next  = no_fill_reg;
    if (in_idle)
      no_fill_next = 1'b0;
    else if (in_flight && inv)
      no_fill_next = 1'b1;
    // Data is always captured so it doubles as the output register even with LB_EN=0.
    if (fill_en) begin
      lb_data_next  = fill_data;
      lb_index_next = fill_index;
      lb_valid_next = LB_EN & ~no_fill_reg & ~inv;
    end
  end

  assign hit     = LB_EN & lb_valid_reg & ~inv & (lb_index_reg == lookup_index);
  assign lb_data = lb_data_reg;

endmodule

// File: rtl/ifu_line_fetcher.sv
// Fetch-side DDR line reader: takes a line index from pc_ctrl, serves it from
// the line buffer or DDR, and returns the line with a one-cycle done pulse.
module ifu_line_fetcher #(
  parameter int IDX_W  = ifu_pkg::IDX_W,
  parameter int LINE_W = ifu_pkg::LINE_W,
  parameter bit LB_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_index_valid,
  input  logic [IDX_W-1:0]  pc_index,
  output logic              pc_index_ready,
  output logic              pc_operation_done,
  output logic [LINE_W-1:0] pc_read_inst,
  input  logic              flush,
  input  logic              inv_line_buf,
  input  logic              mem_stall,
  output logic              ddr_req_valid,
  output logic [IDX_W-1:0]  ddr_req_index,
  input  logic              ddr_req_ready,
  input  logic              ddr_resp_valid,
  input  logic [LINE_W-1:0] ddr_resp_data
);
  import ifu_pkg::*;

  fetch_state_e     state_reg, state_next;
  logic [IDX_W-1:0] req_index_reg, req_index_next;
  logic             lb_hit;
  logic             fill_en;
  logic             in_idle;
  logic             in_flight;
  logic             ready_raw;

  assign in_idle   = (state_reg == ST_IDLE);
  assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_WAIT) || (state_reg == ST_DROP);

  ifu_line_buf #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W),
    .LB_EN  (LB_EN)
  ) u_line_buf (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_index (pc_index),
    .inv          (inv_line_buf),
    .in_idle      (in_idle),
    .in_flight    (in_flight),
    .fill_en      (fill_en),
    .fill_index   (req_index_reg),
    .fill_data    (ddr_resp_data),
    .hit          (lb_hit),
    .lb_data      (pc_read_inst)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      req_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      req_index_reg <= req_index_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    req_index_next    = req_index_reg;
    ready_raw         = 1'b0;
    pc_operation_done = 1'b0;
    ddr_req_valid     = 1'b0;
    fill_en           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_raw = ~mem_stall & ~flush;
        if (pc_index_valid && ready_raw) begin
          req_index_next = pc_index;
          state_next     = lb_hit ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        ddr_req_valid = 1'b1;
        if (ddr_req_ready)
          state_next = flush ? ST_DROP : ST_WAIT;
        else if (flush)
          state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (ddr_resp_valid) begin
          fill_en    = 1'b1;
          state_next = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        // The issued read must still drain before a new request may go out.
        if (ddr_resp_valid) begin
          fill_en    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        pc_operation_done = ~flush;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!reset_n) begin
      ready_raw         = 1'b0;
      pc_operation_done = 1'b0;
      ddr_req_valid     = 1'b0;
    end
  end

  assign pc_index_ready = ready_raw;
  assign ddr_req_index  = req_index_reg;

endmodule

// File: tb/tb_ifu_line_fetcher.sv
// Directed bench for ifu_line_fetcher: miss, hit, flush, stall, invalidate and reset cases.
module tb_ifu_line_fetcher;

  localparam int IDX_W  = 19;
  localparam int LINE_W = 512;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              pc_index_valid;
  logic [IDX_W-1:0]  pc_index;
  logic              pc_index_ready;
  logic              pc_operation_done;
  logic [LINE_W-1:0] pc_read_inst;
  logic              flush;
  logic              inv_line_buf;
  logic              mem_stall;
  logic              ddr_req_valid;
  logic [IDX_W-1:0]  ddr_req_index;
  logic              ddr_req_ready;
  logic              ddr_resp_valid;
  logic [LINE_W-1:0] ddr_resp_data;

  int total = 0;
  int bad = 0;
  int req_count = 0;

  logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;

  ifu_line_fetcher #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W),
    .LB_EN  (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pc_index_valid    (pc_index_valid),
    .pc_index          (pc_index),
    .pc_index_ready    (pc_index_ready),
    .pc_operation_done (pc_operation_done),
    .pc_read_inst      (pc_read_inst),
    .flush             (flush),
    .inv_line_buf      (inv_line_buf),
    .mem_stall         (mem_stall),
    .ddr_req_valid     (ddr_req_valid),
    .ddr_req_index     (ddr_req_index),
    .ddr_req_ready     (ddr_req_ready),
    .ddr_resp_valid    (ddr_resp_valid),
    .ddr_resp_data     (ddr_resp_data)
  );

  always #5 clock = ~clock;

  // Counts DDR request handshakes seen on the bus.
  always @(posedge clock) begin
    if (reset_n && ddr_req_valid && ddr_req_ready)
      req_count <= req_count + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pat_a = {16{32'hA0A0_0001}};
    pat_b = {16{32'hB0B0_0002}};
    pat_c = {16{32'hC0C0_0003}};
    pat_d = {16{32'hD0D0_0004}};
    pat_e = {16{32'hE0E0_0005}};
    pat_f = {16{32'hF0F0_0006}};
    reset_n = 1'b0; pc_index_valid = 1'b0; pc_index = '0; flush = 1'b0;
    inv_line_buf = 1'b0; mem_stall = 1'b0; ddr_req_ready = 1'b0;
    ddr_resp_valid = 1'b0; ddr_resp_data = '0;
    tick(); tick();
    settle();
    chk("rst_ready", pc_index_ready, 0);
    chk("rst_done", pc_operation_done, 0);
    chk("rst_req_valid", ddr_req_valid, 0);
    chk("rst_req_index", ddr_req_index, 0);
    chk("rst_inst", pc_read_inst, 0);
    reset_n = 1'b1; settle();
    chk("idle_ready", pc_index_ready, 1);

    // Miss on 0x00010, DDR ready after 2 cycles, response a few cycles later
    pc_index_valid = 1'b1; pc_index = 19'h00010; settle();
    chk("miss_accept", pc_index_ready, 1);
    tick(); pc_index_valid = 1'b0; settle();
    chk("miss_req_valid", ddr_req_valid, 1);
    chk("miss_req_index", ddr_req_index, 19'h00010);
    chk("miss_req_ready_low", pc_index_ready, 0);
    tick(); ddr_req_ready = 1'b1; settle();
    chk("miss_req_hold", ddr_req_valid, 1);
    chk("miss_req_hold_idx", ddr_req_index, 19'h00010);
    tick(); ddr_req_ready = 1'b0; settle();
    chk("miss_req_drop", ddr_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("miss_wait_nodone", pc_operation_done, 0);
    end
    tick(); ddr_resp_valid = 1'b1; ddr_resp_data = pat_a; settle();
    chk("miss_resp_nodone", pc_operation_done, 0);
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("miss_done", pc_operation_done, 1);
    chk("miss_data", pc_read_inst, pat_a);
    tick(); settle();
    chk("miss_done_pulse", pc_operation_done, 0);
    chk("miss_data_hold", pc_read_inst, pat_a);
    chk("miss_req_count", req_count, 1);

    // Hit on the same line
    pc_index_valid = 1'b1; pc_index = 19'h00010; settle();
    chk("hit_ready", pc_index_ready, 1);
    chk("hit_no_req", ddr_req_valid, 0);
    tick(); pc_index_valid = 1'b0; settle();
    chk("hit_done", pc_operation_done, 1);
    chk("hit_no_req2", ddr_req_valid, 0);
    chk("hit_data", pc_read_inst, pat_a);
    tick(); settle();
    chk("hit_req_count", req_count, 1);

    // Flush while waiting for the response to 0x00020
    pc_index_valid = 1'b1; pc_index = 19'h00020; settle();
    tick(); pc_index_valid = 1'b0; ddr_req_ready = 1'b1; settle();
    chk("fw_req_index", ddr_req_index, 19'h00020);
    tick(); ddr_req_ready = 1'b0; flush = 1'b1; settle();
    chk("fw_nodone_wait", pc_operation_done, 0);
    chk("fw_ready_wait", pc_index_ready, 0);
    tick(); flush = 1'b0; settle();
    chk("fw_ready_drop", pc_index_ready, 0);
    tick(); ddr_resp_valid = 1'b1; ddr_resp_data = pat_b; settle();
    chk("fw_ready_resp", pc_index_ready, 0);
    chk("fw_nodone_resp", pc_operation_done, 0);
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("fw_nodone_after", pc_operation_done, 0);
    chk("fw_ready_idle", pc_index_ready, 1);
    chk("fw_lb_data", pc_read_inst, pat_b);
    pc_index_valid = 1'b1; pc_index = 19'h00020; settle();
    tick(); pc_index_valid = 1'b0; settle();
    chk("fw_hit_done", pc_operation_done, 1);
    chk("fw_hit_data", pc_read_inst, pat_b);
    chk("fw_req_count", req_count, 2);
    tick(); settle();

    // Flush in REQ before the DDR accepts
    pc_index_valid = 1'b1; pc_index = 19'h00050; settle();
    tick(); pc_index_valid = 1'b0; flush = 1'b1; settle();
    chk("fr_req_valid", ddr_req_valid, 1);
    tick(); flush = 1'b0; settle();
    chk("fr_req_dropped", ddr_req_valid, 0);
    chk("fr_idle_ready", pc_index_ready, 1);
    chk("fr_nodone", pc_operation_done, 0);
    chk("fr_req_count", req_count, 2);

    // mem_stall holds off a pending request, accepted as soon as it falls
    mem_stall = 1'b1; pc_index_valid = 1'b1; pc_index = 19'h00060;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_ready", pc_index_ready, 0);
      chk("stall_no_req", ddr_req_valid, 0);
      tick();
    end
    mem_stall = 1'b0; settle();
    chk("stall_release_ready", pc_index_ready, 1);
    tick(); pc_index_valid = 1'b0; ddr_req_ready = 1'b1; settle();
    chk("stall_req_valid", ddr_req_valid, 1);
    chk("stall_req_index", ddr_req_index, 19'h00060);
    tick(); ddr_req_ready = 1'b0; ddr_resp_valid = 1'b1; ddr_resp_data = pat_c;
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("stall_done", pc_operation_done, 1);
    chk("stall_data", pc_read_inst, pat_c);
    tick(); settle();

    // Invalidate during WAIT for 0x00030: response delivered, not retained
    pc_index_valid = 1'b1; pc_index = 19'h00030; settle();
    tick(); pc_index_valid = 1'b0; ddr_req_ready = 1'b1;
    tick(); ddr_req_ready = 1'b0; inv_line_buf = 1'b1; settle();
    chk("inv_nodone_wait", pc_operation_done, 0);
    tick(); inv_line_buf = 1'b0; ddr_resp_valid = 1'b1; ddr_resp_data = pat_d;
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("inv_done", pc_operation_done, 1);
    chk("inv_data", pc_read_inst, pat_d);
    tick();
    pc_index_valid = 1'b1; pc_index = 19'h00030; settle();
    chk("inv_ready", pc_index_ready, 1);
    tick(); pc_index_valid = 1'b0; settle();
    chk("inv_miss_req", ddr_req_valid, 1);
    chk("inv_miss_idx", ddr_req_index, 19'h00030);
    chk("inv_miss_nodone", pc_operation_done, 0);
    ddr_req_ready = 1'b1;
    tick(); ddr_req_ready = 1'b0; ddr_resp_valid = 1'b1; ddr_resp_data = pat_e;
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("inv_refill_done", pc_operation_done, 1);
    chk("inv_refill_data", pc_read_inst, pat_e);
    tick(); settle();
    chk("inv_req_count", req_count, 5);

    // Reset during WAIT; a late response must be ignored
    pc_index_valid = 1'b1; pc_index = 19'h00070; settle();
    tick(); pc_index_valid = 1'b0; ddr_req_ready = 1'b1;
    tick(); ddr_req_ready = 1'b0; reset_n = 1'b0;
    tick(); reset_n = 1'b1; ddr_resp_valid = 1'b1; ddr_resp_data = pat_f; settle();
    chk("mrst_nodone", pc_operation_done, 0);
    chk("mrst_ready", pc_index_ready, 1);
    chk("mrst_no_req", ddr_req_valid, 0);
    tick(); ddr_resp_valid = 1'b0; ddr_resp_data = '0; settle();
    chk("mrst_nodone_late", pc_operation_done, 0);
    chk("mrst_inst_clear", pc_read_inst, 0);
    chk("mrst_req_count", req_count, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
